// File: rtl/spi_io_controller.sv
// rtl/spi_io_controller.sv - byte-wide SPI master (mode 0, MSB first) behind a mapped-IO write port
// Optional feature: define SPI_LOOPBACK_EN to receive from mosi_o instead of miso_i.
module spi_io_controller #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       io_wr_i,
  input  logic [7:0] io_addr_i,
  input  logic [7:0] data_i,
  input  logic       miso_i,
  output logic       spi_clk_o,
  output logic       mosi_o,
  output logic [2:0] spi_addr_o,
  output logic [7:0] rd_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       overrun_o
);

  localparam logic [7:0] DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [2:0] BIT_LAST    = 3'(DATA_WIDTH - 1);
  localparam logic [7:0] ADDR_TXDATA = 8'h00;
  localparam logic [7:0] ADDR_SELECT = 8'h01;
  localparam logic [7:0] ADDR_CLEAR  = 8'h02;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] div_q;
  logic [2:0] bit_q;
  logic [7:0] tx_q;
  logic [7:0] rx_q;
  logic [7:0] rd_q;
  logic       mosi_q;
  logic [2:0] addr_q;
  logic       ovr_q;

  logic tx_wr, sel_wr, clr_wr;
  logic div_last, can_start, start, busy, rx_bit;

  assign tx_wr     = !io_wr_i && (io_addr_i == ADDR_TXDATA);
  assign sel_wr    = !io_wr_i && (io_addr_i == ADDR_SELECT);
  assign clr_wr    = !io_wr_i && (io_addr_i == ADDR_CLEAR);
  assign div_last  = (div_q == DIV_LAST);
  assign can_start = (state_q == IDLE) || (state_q == DONE);
  assign start     = tx_wr && can_start;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso_i;
  assign rx_bit      = mosi_q;
`else
  assign rx_bit      = miso_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOW;
      LOW:     if (div_last) state_d = HIGH;
      HIGH:    if (div_last) state_d = (bit_q == BIT_LAST) ? DONE : LOW;
      DONE:    state_d = start ? LOW : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spi_clk_o = 1'b0;
    busy      = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      LOW:     busy = 1'b1;
      HIGH:    begin
        busy      = 1'b1;
        spi_clk_o = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // Shift datapath: sample on the LOW->HIGH edge, advance mosi on HIGH->LOW.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      div_q  <= '0;
      bit_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      rd_q   <= '0;
      mosi_q <= 1'b0;
      addr_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (start) begin
        tx_q   <= data_i;
        mosi_q <= data_i[7];
        bit_q  <= '0;
        div_q  <= '0;
      end else if (busy) begin
        div_q <= div_last ? 8'd0 : div_q + 8'd1;
        if (state_q == LOW && div_last) begin
          rx_q <= {rx_q[6:0], rx_bit};
        end
        if (state_q == HIGH && div_last) begin
          if (bit_q == BIT_LAST) begin
            rd_q <= rx_q;
          end else begin
            tx_q   <= {tx_q[6:0], 1'b0};
            mosi_q <= tx_q[6];
            bit_q  <= bit_q + 3'd1;
          end
        end
      end

      // Device select is frozen while a byte is on the wire.
      if (sel_wr && !busy) begin
        addr_q <= data_i[2:0];
      end

      if (tx_wr && busy) begin
        ovr_q <= 1'b1;
      end else if (clr_wr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign mosi_o     = mosi_q;
  assign spi_addr_o = addr_q;
  assign rd_data_o  = rd_q;
  assign busy_o     = busy;
  assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_spi_io_controller.sv
// tb/tb_spi_io_controller.sv - self-checking bench for spi_io_controller with a scoreboard queue
module tb_spi_io_controller;
  localparam int C   = 2;
  localparam int LAT = 16 * C + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       io_wr = 1'b1;
  logic [7:0] io_addr = 8'h00;
  logic [7:0] data = 8'h00;
  logic       miso = 1'b0;
  logic       spi_clk, mosi, busy, done, overrun;
  logic [2:0] spi_addr;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  spi_io_controller #(.CLK_DIV(C), .DATA_WIDTH(8)) dut (
    .clk_i(clk), .reset_i(reset), .io_wr_i(io_wr), .io_addr_i(io_addr),
    .data_i(data), .miso_i(miso), .spi_clk_o(spi_clk), .mosi_o(mosi),
    .spi_addr_o(spi_addr), .rd_data_o(rd_data), .busy_o(busy),
    .done_o(done), .overrun_o(overrun)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slave;
    logic [7:0] exp_rd;
  } xfer_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] tx;
    logic [7:0] slave;
  } vec_t;

  xfer_t sb_q[$];
  vec_t  vecs[4];
  int    total = 0;
  int    bad = 0;
  int    abs_cyc = 0;
  int    rise_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    abs_cyc++;
  endtask

  function automatic logic [7:0] rx_expect(input logic [7:0] tx, input logic [7:0] slave);
`ifdef SPI_LOOPBACK_EN
    return tx;
`else
    return slave;
`endif
  endfunction

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    io_wr   = 1'b0;
    io_addr = a;
    data    = d;
    tick();
    io_wr   = 1'b1;
  endtask

  task automatic start_tx(input logic [7:0] tx, input logic [7:0] slave);
    xfer_t x;
    x.tx     = tx;
    x.slave  = slave;
    x.exp_rd = rx_expect(tx, slave);
    sb_q.push_back(x);
    miso = slave[7];
    io_write(8'h00, tx);
  endtask

  // Called at the negedge of cycle 1 of a transfer; slave shifts after each rising spi_clk.
  task automatic watch(input int inj_cyc, input logic [7:0] inj_a, input logic [7:0] inj_d,
                       input bit chain, input logic [7:0] nxt_tx, input logic [7:0] nxt_slave,
                       output int done_at);
    xfer_t      cur;
    int         rises;
    logic [7:0] got;
    bit         prev;
    bit         fin;
    cur     = sb_q[0];
    rises   = 0;
    got     = 8'h00;
    prev    = 1'b0;
    fin     = 1'b0;
    done_at = -1;
    check("busy_cycle1", {31'd0, busy}, 32'd1);
    for (int rel = 1; rel <= LAT + 4 && !fin; rel++) begin
      if (spi_clk && !prev) begin
        got = {got[6:0], mosi};
        rises++;
        rise_total++;
        if (rises < 8) miso = cur.slave[3'(7 - rises)];
      end
      prev = spi_clk;
      if (done) begin
        fin     = 1'b1;
        done_at = abs_cyc;
        io_wr   = 1'b1;
        void'(sb_q.pop_front());
        check("done_latency", rel, LAT);
        check("rd_data", {24'd0, rd_data}, {24'd0, cur.exp_rd});
        check("mosi_bits", {24'd0, got}, {24'd0, cur.tx});
        check("rise_count", rises, 8);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        if (chain) start_tx(nxt_tx, nxt_slave);
        else tick();
      end else begin
        if (rel == inj_cyc) begin
          io_wr   = 1'b0;
          io_addr = inj_a;
          data    = inj_d;
        end else begin
          io_wr = 1'b1;
        end
        tick();
      end
    end
    if (!fin) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int d1, d2, r0, dcount;
    vecs[0] = '{sel: 3'd2, tx: 8'hA5, slave: 8'h3C};
    vecs[1] = '{sel: 3'd1, tx: 8'h00, slave: 8'hFF};
    vecs[2] = '{sel: 3'd3, tx: 8'hFF, slave: 8'h00};
    vecs[3] = '{sel: 3'd5, tx: 8'h6B, slave: 8'hD2};

    reset = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {17'd0, spi_clk, mosi, spi_addr, rd_data, busy, done, overrun}, 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      io_write(8'h01, {5'd0, vecs[i].sel});
      start_tx(vecs[i].tx, vecs[i].slave);
      watch(0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, d1);
      check("spi_addr_vec", {29'd0, spi_addr}, {29'd0, vecs[i].sel});
    end

    // Overrun: second TXDATA while busy is dropped and latches overrun.
    start_tx(8'h11, 8'h96);
    watch(5, 8'h00, 8'h22, 1'b0, 8'h00, 8'h00, d1);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    repeat (3) tick();
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    check("idle_after_drop", {31'd0, busy}, 32'd0);
    io_write(8'h02, 8'h00);
    check("overrun_clear", {31'd0, overrun}, 32'd0);

    // SELECT while busy is ignored.
    io_write(8'h01, 8'h01);
    start_tx(8'h5C, 8'hC5);
    watch(7, 8'h01, 8'h03, 1'b0, 8'h00, 8'h00, d1);
    check("select_busy_held", {29'd0, spi_addr}, 32'd1);

    // Back-to-back: second TXDATA written during the DONE cycle.
    r0 = rise_total;
    start_tx(8'h81, 8'h55);
    watch(0, 8'h00, 8'h00, 1'b1, 8'h7E, 8'hAA, d1);
    check("b2b_no_idle", {31'd0, busy}, 32'd1);
    watch(0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, d2);
    check("b2b_done_gap", d2 - d1, LAT);
    check("b2b_rises", rise_total - r0, 16);

    // Mid-transfer reset at cycle 10.
    io_write(8'h01, 8'h02);
    start_tx(8'h5A, 8'h99);
    io_write(8'h00, 8'h33);
    repeat (8) tick();
    check("pre_reset_addr", {29'd0, spi_addr}, 32'd2);
    check("pre_reset_ovr", {31'd0, overrun}, 32'd1);
    reset = 1'b0;
    tick();
    check("midreset_outputs", {17'd0, spi_clk, mosi, spi_addr, rd_data, busy, done, overrun}, 32'd0);
    reset = 1'b1;
    void'(sb_q.pop_front());
    dcount = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      if (done) dcount++;
      tick();
    end
    check("no_done_after_reset", dcount, 0);
    start_tx(8'hF0, 8'h0F);
    watch(0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, d1);
    check("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
